// File: rtl/cache_controller.sv
// Write-back, write-allocate controller for a direct-mapped
// 256-line, one-word-per-line cache array with a memory-side handshake.
module cache_controller #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic             CpuReq,
    input  logic             CpuWE,
    input  logic [31:0]      CpuAddr,
    input  logic [31:0]      CpuWData,
    output logic             CpuReady,
    output logic [31:0]      CpuRData,
    output logic [31:0]      CacheAddr,
    output logic             CacheWE,
    output logic [31:0]      CacheWData,
    output logic             CacheDirty,
    output logic             CacheReset,
    input  logic             CacheHit,
    input  logic             CacheV,
    input  logic             CacheD,
    input  logic [31:0]      CacheRData,
    input  logic [21:0]      CacheTag,
    output logic             MemReq,
    output logic             MemWE,
    output logic [31:0]      MemAddr,
    output logic [31:0]      MemWData,
    input  logic             MemReady,
    input  logic [31:0]      MemRData,
    output logic [CNT_W-1:0] HitCount,
    output logic [CNT_W-1:0] MissCount,
    output logic [CNT_W-1:0] WbCount
);

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        ALLOCATE
    } state_t;

    state_t      state;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic        we_reg;
    logic        refilled;
    logic [21:0] victim_tag;
    logic [31:0] victim_data;

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= IDLE;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            we_reg      <= 1'b0;
            refilled    <= 1'b0;
            victim_tag  <= '0;
            victim_data <= '0;
            HitCount    <= '0;
            MissCount   <= '0;
            WbCount     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (CpuReq) begin
                        addr_reg  <= CpuAddr;
                        wdata_reg <= CpuWData;
                        we_reg    <= CpuWE;
                        refilled  <= 1'b0;
                        state     <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (CacheHit) begin
                        // the hit that follows a refill belongs to the miss
                        if (!refilled)
                            HitCount <= HitCount + CNT_W'(1);
                        state <= IDLE;
                    end else begin
                        MissCount <= MissCount + CNT_W'(1);
                        if (CacheV && CacheD) begin
                            victim_tag  <= CacheTag;
                            victim_data <= CacheRData;
                            state       <= WRITEBACK;
                        end else begin
                            state <= ALLOCATE;
                        end
                    end
                end
                WRITEBACK: begin
                    if (MemReady) begin
                        WbCount <= WbCount + CNT_W'(1);
                        state   <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    if (MemReady) begin
                        refilled <= 1'b1;
                        state    <= COMPARE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        CpuReady   = 1'b0;
        CpuRData   = '0;
        CacheAddr  = {addr_reg[31:2], 2'b00};
        CacheWE    = 1'b0;
        CacheWData = '0;
        CacheDirty = 1'b0;
        CacheReset = ~Reset_n;
        MemReq     = 1'b0;
        MemWE      = 1'b0;
        MemAddr    = '0;
        MemWData   = '0;
        unique case (state)
            IDLE: ;
            COMPARE: begin
                if (CacheHit) begin
                    CpuReady = 1'b1;
                    if (we_reg) begin
                        CacheWE    = 1'b1;
                        CacheWData = wdata_reg;
                        CacheDirty = 1'b1;
                    end else begin
                        CpuRData = CacheRData;
                    end
                end
            end
            WRITEBACK: begin
                MemReq   = 1'b1;
                MemWE    = 1'b1;
                MemAddr  = {victim_tag, addr_reg[9:2], 2'b00};
                MemWData = victim_data;
            end
            ALLOCATE: begin
                MemReq  = 1'b1;
                MemAddr = {addr_reg[31:2], 2'b00};
                if (MemReady) begin
                    CacheWE    = 1'b1;
                    CacheWData = MemRData;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_controller.sv
// Randomized scoreboard bench for cache_controller with behavioural
// cache array, backing memory and a flat-memory reference model.
module tb_cache_controller;

    logic        CLK = 1'b0;
    logic        Reset_n;
    logic        CpuReq;
    logic        CpuWE;
    logic [31:0] CpuAddr;
    logic [31:0] CpuWData;
    logic        CpuReady;
    logic [31:0] CpuRData;
    logic [31:0] CacheAddr;
    logic        CacheWE;
    logic [31:0] CacheWData;
    logic        CacheDirty;
    logic        CacheReset;
    logic        CacheHit;
    logic        CacheV;
    logic        CacheD;
    logic [31:0] CacheRData;
    logic [21:0] CacheTag;
    logic        MemReq;
    logic        MemWE;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic        MemReady;
    logic [31:0] MemRData;
    logic [31:0] HitCount;
    logic [31:0] MissCount;
    logic [31:0] WbCount;

    always #5 CLK = ~CLK;

    cache_controller #(.CNT_W(32)) dut (
        .CLK(CLK), .Reset_n(Reset_n),
        .CpuReq(CpuReq), .CpuWE(CpuWE),
        .CpuAddr(CpuAddr), .CpuWData(CpuWData),
        .CpuReady(CpuReady), .CpuRData(CpuRData),
        .CacheAddr(CacheAddr), .CacheWE(CacheWE),
        .CacheWData(CacheWData), .CacheDirty(CacheDirty),
        .CacheReset(CacheReset), .CacheHit(CacheHit),
        .CacheV(CacheV), .CacheD(CacheD),
        .CacheRData(CacheRData), .CacheTag(CacheTag),
        .MemReq(MemReq), .MemWE(MemWE),
        .MemAddr(MemAddr), .MemWData(MemWData),
        .MemReady(MemReady), .MemRData(MemRData),
        .HitCount(HitCount), .MissCount(MissCount),
        .WbCount(WbCount)
    );

    int vectors = 0;
    int miscompares = 0;

    // cache array model
    logic [21:0] arr_tag  [256];
    logic [31:0] arr_data [256];
    logic        arr_v    [256];
    logic        arr_d    [256];
    wire  [7:0]  aidx = CacheAddr[9:2];

    assign CacheHit   = arr_v[aidx] && (arr_tag[aidx] == CacheAddr[31:10]);
    assign CacheV     = arr_v[aidx];
    assign CacheD     = arr_d[aidx];
    assign CacheRData = arr_data[aidx];
    assign CacheTag   = arr_tag[aidx];

    always @(posedge CLK or posedge CacheReset) begin
        if (CacheReset) begin
            for (int i = 0; i < 256; i++) begin
                arr_v[i]    <= 1'b0;
                arr_d[i]    <= 1'b0;
                arr_tag[i]  <= '0;
                arr_data[i] <= '0;
            end
        end else if (CacheWE) begin
            arr_tag[aidx]  <= CacheAddr[31:10];
            arr_data[aidx] <= CacheWData;
            arr_v[aidx]    <= 1'b1;
            arr_d[aidx]    <= CacheDirty;
        end
    end

    // backing memory and reference flat memory
    logic [31:0] mem_bk  [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] bk_rd(input logic [31:0] a);
        return mem_bk.exists(a) ? mem_bk[a] : init_val(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    // reference cache occupancy, used only for expected statistics
    logic [21:0] ref_tag [256];
    logic        ref_v   [256];
    logic        ref_d   [256];
    logic [31:0] exp_hits, exp_misses, exp_wbs;

    typedef struct {
        logic        we;
        logic [31:0] rdata;
        logic [31:0] hits;
        logic [31:0] misses;
        logic [31:0] wbs;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    logic cnt_pend = 1'b0;

    always @(negedge CLK) begin
        if (cnt_pend) begin
            cnt_pend = 1'b0;
            vectors++;
            if (HitCount !== cur.hits || MissCount !== cur.misses ||
                WbCount !== cur.wbs) begin
                miscompares++;
                $display("FAIL counters: got h=%0d m=%0d w=%0d want h=%0d m=%0d w=%0d",
                         HitCount, MissCount, WbCount,
                         cur.hits, cur.misses, cur.wbs);
            end
        end
        if (Reset_n && CpuReady) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL spurious_ready: got CpuReady=1 want no pending request");
            end else begin
                cur = sb.pop_front();
                if (!cur.we) begin
                    vectors++;
                    if (CpuRData !== cur.rdata) begin
                        miscompares++;
                        $display("FAIL load_data: got %h want %h", CpuRData, cur.rdata);
                    end
                end
                cnt_pend = 1'b1;
            end
        end
    end

    // memory responder
    logic slow = 1'b0;

    initial begin
        logic [31:0] a, wd;
        logic        w, aborted;
        int          lat;
        MemReady = 1'b0;
        MemRData = '0;
        forever begin
            @(negedge CLK);
            if (MemReq && Reset_n) begin
                lat = slow ? 30 : int'($urandom_range(0, 3));
                aborted = 1'b0;
                for (int k = 0; k < lat; k++) begin
                    @(negedge CLK);
                    if (!MemReq) begin
                        aborted = 1'b1;
                        break;
                    end
                end
                if (!aborted && MemReq) begin
                    a  = MemAddr;
                    w  = MemWE;
                    wd = MemWData;
                    MemRData = w ? 32'h0 : bk_rd(a);
                    MemReady = 1'b1;
                    @(posedge CLK);
                    if (Reset_n && w) begin
                        vectors++;
                        if (wd !== ref_rd(a)) begin
                            miscompares++;
                            $display("FAIL writeback_data @%h: got %h want %h",
                                     a, wd, ref_rd(a));
                        end
                        mem_bk[a] = wd;
                    end
                    #1 MemReady = 1'b0;
                end
            end
        end
    end

    logic b2b = 1'b0;

    task automatic gap(input int n);
        if (n > 0) begin
            b2b = 1'b0;
            repeat (n) @(negedge CLK);
        end
    endtask

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic issue(input logic we, input logic [31:0] addr,
                         input logic [31:0] wd);
        exp_t        e;
        logic [31:0] wa;
        logic [7:0]  idx;
        logic [21:0] tg;
        logic        hit, saw_mem;
        int          cyc;
        wa  = {addr[31:2], 2'b00};
        idx = wa[9:2];
        tg  = wa[31:10];
        hit = ref_v[idx] && ref_tag[idx] == tg;
        if (hit) begin
            exp_hits++;
        end else begin
            exp_misses++;
            if (ref_v[idx] && ref_d[idx])
                exp_wbs++;
            ref_tag[idx] = tg;
            ref_v[idx]   = 1'b1;
            ref_d[idx]   = 1'b0;
        end
        if (we) begin
            ref_d[idx]  = 1'b1;
            ref_mem[wa] = wd;
        end
        e.we     = we;
        e.rdata  = ref_rd(wa);
        e.hits   = exp_hits;
        e.misses = exp_misses;
        e.wbs    = exp_wbs;
        sb.push_back(e);
        CpuReq   = 1'b1;
        CpuWE    = we;
        CpuAddr  = addr;
        CpuWData = wd;
        cyc      = 0;
        saw_mem  = 1'b0;
        do begin
            @(negedge CLK);
            cyc++;
            if (MemReq)
                saw_mem = 1'b1;
        end while (!CpuReady && cyc < 300);
        if (!CpuReady) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout @%h: got no CpuReady want CpuReady", wa);
            void'(sb.pop_back());
        end else if (hit) begin
            vectors++;
            if (cyc != (b2b ? 2 : 1) || saw_mem) begin
                miscompares++;
                $display("FAIL hit_latency @%h: got %0d cycles mem=%0b want %0d cycles mem=0",
                         wa, cyc, saw_mem, b2b ? 2 : 1);
            end
        end
        CpuReq = 1'b0;
        b2b    = 1'b1;
    endtask

    task automatic ref_reset();
        for (int i = 0; i < 256; i++) begin
            ref_v[i] = 1'b0;
            ref_d[i] = 1'b0;
            ref_tag[i] = '0;
        end
        exp_hits   = 0;
        exp_misses = 0;
        exp_wbs    = 0;
        ref_mem    = mem_bk;
    endtask

    initial begin
        logic [21:0] tg;
        logic [7:0]  ix;
        int          cyc;
        Reset_n  = 1'b0;
        CpuReq   = 1'b0;
        CpuWE    = 1'b0;
        CpuAddr  = '0;
        CpuWData = '0;
        mem_bk[32'h404] = 32'hDEAD_BEEF;
        ref_reset();
        #1;
        check("reset_cache_reset", {31'd0, CacheReset}, 32'd1);
        check("reset_outputs", {CpuReady, MemReq, CacheWE, CacheDirty},
              32'd0);
        check("reset_cache_addr", CacheAddr, 32'd0);
        check("reset_counters", HitCount | MissCount | WbCount, 32'd0);
        repeat (2) @(negedge CLK);
        Reset_n = 1'b1;
        @(negedge CLK);
        check("cache_reset_released", {31'd0, CacheReset}, 32'd0);

        issue(1'b0, 32'h0000_0404, 32'h0);
        gap(1);
        issue(1'b0, 32'h0000_0404, 32'h0);
        gap(2);
        issue(1'b1, 32'h0000_0404, 32'h1234);
        issue(1'b0, 32'h0000_0404, 32'h0);
        issue(1'b0, 32'h0000_0804, 32'h0);
        gap(1);
        issue(1'b1, 32'h0000_0C08, 32'hCAFE_0C08);
        issue(1'b0, 32'h0000_0C0B, 32'h0);
        issue(1'b0, 32'h0000_0404, 32'h0);

        for (int n = 0; n < 400; n++) begin
            tg = ($urandom_range(0, 4) == 4) ? 22'h3F_FFFF
                                             : 22'($urandom_range(0, 3));
            ix = ($urandom_range(0, 9) == 9) ? 8'hFF
                                             : 8'($urandom_range(0, 7));
            issue(1'($urandom), {tg, ix, 2'($urandom)}, $urandom);
            gap(int'($urandom_range(0, 2)) - 1 > 0 ? 1 : 0);
        end

        gap(2);
        issue(1'b1, 32'h0000_0404, 32'h0BAD_F00D);
        gap(2);
        slow     = 1'b1;
        CpuReq   = 1'b1;
        CpuWE    = 1'b0;
        CpuAddr  = 32'h0000_0804;
        cyc      = 0;
        while (!(MemReq && MemWE) && cyc < 50) begin
            @(negedge CLK);
            cyc++;
        end
        vectors++;
        if (!(MemReq && MemWE)) begin
            miscompares++;
            $display("FAIL reach_writeback: got MemReq=%0b MemWE=%0b want 1 1",
                     MemReq, MemWE);
        end
        @(negedge CLK);
        Reset_n = 1'b0;
        #1;
        check("midwb_memreq", {31'd0, MemReq}, 32'd0);
        check("midwb_cache_reset", {31'd0, CacheReset}, 32'd1);
        check("midwb_counters", HitCount | MissCount | WbCount, 32'd0);
        check("midwb_ready", {31'd0, CpuReady}, 32'd0);
        CpuReq = 1'b0;
        repeat (2) @(negedge CLK);
        slow    = 1'b0;
        Reset_n = 1'b1;
        ref_reset();
        gap(1);
        issue(1'b0, 32'h0000_0804, 32'h0);
        issue(1'b0, 32'h0000_0404, 32'h0);
        issue(1'b0, 32'h0000_0404, 32'h0);

        cyc = 0;
        while ((sb.size() != 0 || cnt_pend) && cyc < 20) begin
            @(negedge CLK);
            cyc++;
        end
        repeat (2) @(negedge CLK);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
